// File: rtl/send_cmd_pkg.sv
// rtl/send_cmd_pkg.sv - register map, STATUS bit positions and issue FSM states
package send_cmd_pkg;

  localparam logic [13:0] REG_CTRL     = 14'h000;
  localparam logic [13:0] REG_STATUS   = 14'h001;
  localparam logic [13:0] REG_CMD_PUSH = 14'h002;
  localparam logic [13:0] REG_QLEVEL   = 14'h003;
  localparam logic [13:0] REG_IRQ_EN   = 14'h004;
  // CH_TIMER block lives at word offsets 0x10..0x1F
  localparam logic [9:0]  REG_TMR_PAGE = 10'h001;

  localparam int B_CAL_OK     = 0;
  localparam int B_CAL_FAIL   = 1;
  localparam int B_SETUP_DONE = 2;
  localparam int B_BUSY       = 3;
  localparam int B_Q_FULL     = 4;
  localparam int B_Q_EMPTY    = 5;
  localparam int B_STICKY_LSB = 8;
  localparam int STICKY_W     = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK
  } state_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/send_cmd_pcie_mc_if.sv
// rtl/send_cmd_pcie_mc_if.sv - Avalon-MM register bus between PCIe BAR host and the block
interface send_cmd_pcie_mc_if;
  logic        read;
  logic        write;
  logic [15:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        rd_valid;

  modport master (output read, write, addr, write_data, input read_data, rd_valid);
  modport slave  (input read, write, addr, write_data, output read_data, rd_valid);
endinterface

// File: rtl/send_cmd_fifo.sv
// rtl/send_cmd_fifo.sv - synchronous command descriptor FIFO with flush and level
module send_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  // push is only presented when there is room or a pop frees a slot this cycle
  logic do_push;
  logic do_pop;
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/send_cmd_pcie_mc.sv
// rtl/send_cmd_pcie_mc.sv - multi-channel command register block: decode, registers, issue FSM, ack timer
module send_cmd_pcie_mc
  import send_cmd_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int RAM_ADDR_W = 6,
  parameter int QDEPTH     = 8,
  parameter int ACK_TMO    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  send_cmd_pcie_mc_if.slave             avalon_mm,
  output logic [RAM_ADDR_W-1:0]         start_ram_addr,
  output logic [ch_width(NUM_CH)-1:0]   send_ch,
  output logic [31:0]                   send_ch_timer,
  output logic                          send_cmd,
  input  logic                          send_ack,
  input  logic                          ddr_local_cal_success,
  input  logic                          ddr_local_cal_fail,
  input  logic                          ddr_setup_done,
  input  logic                          system_main_reset,
  input  logic                          ddr_avalon_rst,
  input  logic                          board_reset,
  output logic                          ddr_setup_cmd,
  output logic                          irq
);
  localparam int CH_W = ch_width(NUM_CH);
  localparam int EW   = RAM_ADDR_W + 4;
  localparam int LW   = $clog2(QDEPTH) + 1;
  localparam int TW   = $clog2(ACK_TMO);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TMO - 1);

  logic [13:0] word;
  logic [31:0] wdata;
  logic        unused_addr_lsbs;
  assign word             = avalon_mm.addr[15:2];
  assign wdata            = avalon_mm.write_data;
  assign unused_addr_lsbs = ^avalon_mm.addr[1:0];

  logic wr_ctrl, wr_status, wr_push, wr_irq_en, tmr_hit;
  logic [CH_W-1:0] tmr_idx;
  assign wr_ctrl   = avalon_mm.write && (word == REG_CTRL);
  assign wr_status = avalon_mm.write && (word == REG_STATUS);
  assign wr_push   = avalon_mm.write && (word == REG_CMD_PUSH);
  assign wr_irq_en = avalon_mm.write && (word == REG_IRQ_EN);
  assign tmr_hit   = (word[13:4] == REG_TMR_PAGE) && ({1'b0, word[3:0]} < 5'(NUM_CH));
  assign tmr_idx   = word[CH_W-1:0];

  state_t              state;
  logic [TW-1:0]       ack_cnt;
  logic [31:0]         ch_timer [NUM_CH];
  logic [STICKY_W-1:0] sticky;
  logic [STICKY_W-1:0] irq_en;

  logic            q_full, q_empty;
  logic [LW-1:0]   q_level;
  logic [EW-1:0]   fifo_din, fifo_dout;
  logic            fifo_push, fifo_pop, fifo_flush;
  logic [3:0]      push_ch, head_ch;
  logic            ch_ok, push_req, ovf_set, issue_go, tmo_set;

  assign push_ch    = wdata[19:16];
  assign ch_ok      = {1'b0, push_ch} < 5'(NUM_CH);
  assign fifo_flush = wr_ctrl && wdata[1];
  assign issue_go   = (state == S_IDLE) && !q_empty && ddr_local_cal_success &&
                      ddr_setup_done && !ddr_local_cal_fail;
  assign fifo_pop   = issue_go;
  // a push coinciding with a flush is discarded silently, not counted as overflow
  assign push_req   = wr_push && !fifo_flush;
  assign fifo_push  = push_req && ch_ok && (!q_full || fifo_pop);
  assign ovf_set    = push_req && !(ch_ok && (!q_full || fifo_pop));
  assign fifo_din   = {push_ch, wdata[RAM_ADDR_W-1:0]};
  assign head_ch    = fifo_dout[EW-1 -: 4];
  assign tmo_set    = (state == S_WAIT_ACK) && !send_ack && (ack_cnt == TMO_LAST);

  send_cmd_fifo #(.WIDTH(EW), .DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (q_full),
    .empty (q_empty),
    .level (q_level)
  );

  logic [STICKY_W-1:0] sticky_set, sticky_w1c;
  assign sticky_set = {tmo_set, ovf_set, board_reset, ddr_avalon_rst,
                       system_main_reset, ddr_local_cal_fail};
  assign sticky_w1c = wr_status ? wdata[B_STICKY_LSB +: STICKY_W] : '0;

  logic [31:0] status_word, rd_mux;
  always_comb begin
    status_word = '0;
    status_word[B_CAL_OK]     = ddr_local_cal_success;
    status_word[B_CAL_FAIL]   = ddr_local_cal_fail;
    status_word[B_SETUP_DONE] = ddr_setup_done;
    status_word[B_BUSY]       = (state != S_IDLE);
    status_word[B_Q_FULL]     = q_full;
    status_word[B_Q_EMPTY]    = q_empty;
    status_word[B_STICKY_LSB +: STICKY_W] = sticky;
  end

  always_comb begin
    rd_mux = '0;
    if (tmr_hit) begin
      rd_mux = ch_timer[tmr_idx];
    end else begin
      case (word)
        REG_STATUS: rd_mux = status_word;
        REG_QLEVEL: rd_mux = 32'(q_level);
        REG_IRQ_EN: rd_mux[B_STICKY_LSB +: STICKY_W] = irq_en;
        default:    rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      avalon_mm.read_data <= '0;
      avalon_mm.rd_valid  <= 1'b0;
      ddr_setup_cmd       <= 1'b0;
      irq_en              <= '0;
      sticky              <= '0;
      for (int i = 0; i < NUM_CH; i++) ch_timer[i] <= '0;
    end else begin
      avalon_mm.rd_valid <= avalon_mm.read;
      if (avalon_mm.read) avalon_mm.read_data <= rd_mux;
      ddr_setup_cmd <= wr_ctrl && wdata[0];
      if (wr_irq_en) irq_en <= wdata[B_STICKY_LSB +: STICKY_W];
      // set wins over a simultaneous write-one-to-clear
      sticky <= (sticky & ~sticky_w1c) | sticky_set;
      if (avalon_mm.write && tmr_hit) ch_timer[tmr_idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      send_cmd       <= 1'b0;
      start_ram_addr <= '0;
      send_ch        <= '0;
      send_ch_timer  <= '0;
      ack_cnt        <= '0;
    end else begin
      send_cmd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue_go) begin
            state          <= S_ISSUE;
            send_cmd       <= 1'b1;
            start_ram_addr <= fifo_dout[RAM_ADDR_W-1:0];
            send_ch        <= head_ch[CH_W-1:0];
            send_ch_timer  <= ch_timer[head_ch[CH_W-1:0]];
            ack_cnt        <= '0;
          end
        end
        S_ISSUE: begin
          state   <= S_WAIT_ACK;
          ack_cnt <= ack_cnt + TW'(1);
        end
        S_WAIT_ACK: begin
          // counter started on the send_cmd cycle, so the flag lands ACK_TMO cycles after it
          if (send_ack || ack_cnt == TMO_LAST) begin
            state <= S_IDLE;
          end else begin
            ack_cnt <= ack_cnt + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign irq = |(sticky & irq_en);

endmodule

// File: tb/tb_send_cmd_pcie_mc.sv
// tb/tb_send_cmd_pcie_mc.sv - directed bench with cycle-level reference model for send_cmd_pcie_mc
module tb_send_cmd_pcie_mc;
  localparam int NUM_CH     = 4;
  localparam int RAM_ADDR_W = 6;
  localparam int QDEPTH     = 8;
  localparam int ACK_TMO    = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [RAM_ADDR_W-1:0] start_ram_addr;
  logic [1:0]  send_ch;
  logic [31:0] send_ch_timer;
  logic send_cmd, ddr_setup_cmd, irq;
  logic send_ack = 0, cal_ok = 1, cal_fail = 0, setup_done = 1;
  logic main_rst = 0, ddr_rst = 0, board_rst = 0;

  send_cmd_pcie_mc_if bus ();

  send_cmd_pcie_mc #(.NUM_CH(NUM_CH), .RAM_ADDR_W(RAM_ADDR_W), .QDEPTH(QDEPTH), .ACK_TMO(ACK_TMO)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .avalon_mm             (bus),
    .start_ram_addr        (start_ram_addr),
    .send_ch               (send_ch),
    .send_ch_timer         (send_ch_timer),
    .send_cmd              (send_cmd),
    .send_ack              (send_ack),
    .ddr_local_cal_success (cal_ok),
    .ddr_local_cal_fail    (cal_fail),
    .ddr_setup_done        (setup_done),
    .system_main_reset     (main_rst),
    .ddr_avalon_rst        (ddr_rst),
    .board_reset           (board_rst),
    .ddr_setup_cmd         (ddr_setup_cmd),
    .irq                   (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: cycle numbers and a queue of {ch, addr} descriptors
  logic [9:0]  mq [$];
  logic [31:0] m_timer [NUM_CH];
  logic [5:0]  m_sticky = '0, m_irq_en = '0;
  int  cyc = 0, m_free_at = 0, m_t_issue = 0;
  bit  m_active = 0, m_tmo_pend = 0, model_ready = 0;
  logic        e_rd_valid, e_send_cmd, e_setup, e_irq;
  logic [31:0] e_read_data, e_timer;
  logic [5:0]  e_addr;
  logic [3:0]  e_ch;
  logic [13:0] mw;
  logic [5:0]  mset, mw1c;
  logic [9:0]  ment;
  bit  mpop, mflush;
  int  msize, mch;

  function automatic logic [31:0] model_read(input logic [13:0] w, input int c);
    logic [31:0] r = '0;
    if (w == 14'h1) begin
      r[0] = cal_ok; r[1] = cal_fail; r[2] = setup_done;
      r[3] = m_active && c >= m_t_issue && c < m_free_at;
      r[4] = (mq.size() == QDEPTH);
      r[5] = (mq.size() == 0);
      r[13:8] = m_sticky;
    end else if (w == 14'h3) begin
      r = 32'(mq.size());
    end else if (w == 14'h4) begin
      r[13:8] = m_irq_en;
    end else if (int'(w) >= 16 && int'(w) < 16 + NUM_CH) begin
      r = m_timer[int'(w) - 16];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      for (int i = 0; i < NUM_CH; i++) m_timer[i] = '0;
      m_sticky = '0; m_irq_en = '0;
      m_active = 0; m_tmo_pend = 0; m_free_at = cyc + 1;
      e_rd_valid = 0; e_read_data = '0; e_send_cmd = 0; e_setup = 0; e_irq = 0;
      e_timer = '0; e_addr = '0; e_ch = '0;
      model_ready = 1;
    end else begin
      mw = bus.addr[15:2];
      e_rd_valid = bus.read;
      if (bus.read) e_read_data = model_read(mw, cyc);
      e_setup = bus.write && mw == 14'h0 && bus.write_data[0];
      mflush  = bus.write && mw == 14'h0 && bus.write_data[1];
      mset = {2'b00, board_rst, ddr_rst, main_rst, cal_fail};
      if (m_tmo_pend && cyc > m_t_issue && send_ack) begin
        m_free_at = cyc + 1; m_tmo_pend = 0;
      end
      if (m_tmo_pend && cyc == m_t_issue + ACK_TMO - 1) begin
        mset[5] = 1'b1; m_tmo_pend = 0;
      end
      msize = mq.size();
      e_send_cmd = 0; mpop = 0;
      if (cyc >= m_free_at && msize > 0 && cal_ok && setup_done && !cal_fail) begin
        mpop = 1; ment = mq[0];
        e_send_cmd = 1; e_addr = ment[5:0]; e_ch = ment[9:6];
        e_timer = m_timer[int'(ment[9:6])];
        m_active = 1; m_t_issue = cyc + 1; m_free_at = cyc + 1 + ACK_TMO; m_tmo_pend = 1;
        void'(mq.pop_front());
      end
      if (bus.write && mw == 14'h2 && !mflush) begin
        mch = int'(bus.write_data[19:16]);
        if (mch >= NUM_CH || (msize == QDEPTH && !mpop)) mset[4] = 1'b1;
        else mq.push_back({bus.write_data[19:16], bus.write_data[5:0]});
      end
      if (mflush) mq.delete();
      mw1c = (bus.write && mw == 14'h1) ? bus.write_data[13:8] : '0;
      m_sticky = (m_sticky & ~mw1c) | mset;
      if (bus.write && mw == 14'h4) m_irq_en = bus.write_data[13:8];
      if (bus.write && int'(mw) >= 16 && int'(mw) < 16 + NUM_CH) m_timer[int'(mw) - 16] = bus.write_data;
      e_irq = |(m_sticky & m_irq_en);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      chk("rd_valid", 32'(bus.rd_valid), 32'(e_rd_valid));
      if (e_rd_valid) chk("read_data", bus.read_data, e_read_data);
      chk("send_cmd", 32'(send_cmd), 32'(e_send_cmd));
      chk("start_ram_addr", 32'(start_ram_addr), 32'(e_addr));
      chk("send_ch", 32'(send_ch), 32'(e_ch));
      chk("send_ch_timer", send_ch_timer, e_timer);
      chk("ddr_setup_cmd", 32'(ddr_setup_cmd), 32'(e_setup));
      chk("irq", 32'(irq), 32'(e_irq));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    bus.write = 1'b1; bus.addr = a; bus.write_data = d;
    tick(1);
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    bus.read = 1'b1; bus.addr = a;
    tick(1);
    bus.read = 1'b0;
    chk("rd_valid_latency", 32'(bus.rd_valid), 32'd1);
    d = bus.read_data;
  endtask

  task automatic wait_send(input string name);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (send_cmd === 1'b1) found = 1;
      else tick(1);
    end
    chk({name, "_send_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] d;
  int k;

  initial begin
    bus.read = 0; bus.write = 0; bus.addr = '0; bus.write_data = '0;
    tick(3);
    rst = 1'b0;

    // 1: reset status
    bus_read(16'h0004, d);
    chk("t1_status", d, 32'h25);

    // 2: single command with channel timer
    bus_write(16'h0048, 32'h1234);
    bus_write(16'h0008, 32'h0002_0015);
    wait_send("t2");
    chk("t2_ch", 32'(send_ch), 32'd2);
    chk("t2_addr", 32'(start_ram_addr), 32'h15);
    chk("t2_timer", send_ch_timer, 32'h1234);
    tick(3); send_ack = 1; tick(1); send_ack = 0;
    tick(1);
    bus_read(16'h0004, d);
    chk("t2_idle_status", d, 32'h25);

    // 3: queue fills while DDR not ready, then drains in order
    setup_done = 0;
    for (int i = 0; i <= QDEPTH; i++) bus_write(16'h0008, {12'h0, 4'(i % NUM_CH), 10'h0, 6'(6'h20 + i)});
    bus_read(16'h000C, d);
    chk("t3_qlevel", d, 32'd8);
    bus_read(16'h0004, d);
    chk("t3_ovf_full", d & 32'h1010, 32'h1010);
    bus_write(16'h0004, 32'h1000);
    setup_done = 1;
    for (int i = 0; i < QDEPTH; i++) begin
      wait_send("t3");
      chk("t3_order_addr", 32'(start_ram_addr), 32'h20 + 32'(i));
      chk("t3_order_ch", 32'(send_ch), 32'(i % NUM_CH));
      tick(1); send_ack = 1; tick(1); send_ack = 0;
    end
    tick(6);

    // 4: ack timeout
    bus_write(16'h0010, 32'h2000);
    bus_write(16'h0008, 32'h0001_0003);
    wait_send("t4");
    k = 0;
    for (int i = 1; i <= ACK_TMO + 10 && k == 0; i++) begin
      tick(1);
      if (irq === 1'b1) k = i;
    end
    chk("t4_tmo_cycles", 32'(k), 32'(ACK_TMO));
    bus_write(16'h0004, 32'h2000);
    chk("t4_irq_cleared", 32'(irq), 32'd0);
    bus_write(16'h0010, 32'h0);

    // 5: board reset sticky, set beats W1C
    board_rst = 1; tick(1); board_rst = 0;
    bus_read(16'h0004, d);
    chk("t5_b11_set", 32'(d[11]), 32'd1);
    board_rst = 1;
    bus_write(16'h0004, 32'h0800);
    board_rst = 0;
    bus_read(16'h0004, d);
    chk("t5_b11_kept", 32'(d[11]), 32'd1);
    bus_write(16'h0004, 32'h0800);
    bus_read(16'h0004, d);
    chk("t5_b11_clr", 32'(d[11]), 32'd0);
    bus_write(16'h0008, 32'h0007_0001);
    bus_write(16'h0010, 32'h1000);
    chk("t5_badch_irq", 32'(irq), 32'd1);

    // 6: flush + setup pulse, then reset during WAIT_ACK
    setup_done = 0;
    for (int i = 0; i < 3; i++) bus_write(16'h0008, 32'h0000_0010 + 32'(i));
    bus_write(16'h0000, 32'h3);
    chk("t6_setup_pulse", 32'(ddr_setup_cmd), 32'd1);
    tick(1);
    chk("t6_setup_end", 32'(ddr_setup_cmd), 32'd0);
    bus_read(16'h000C, d);
    chk("t6_qlevel", d, 32'd0);
    setup_done = 1;
    bus_write(16'h0008, 32'h0002_003F);
    wait_send("t6");
    tick(2);
    rst = 1; tick(1);
    chk("t6_rst_outs", {send_cmd, ddr_setup_cmd, irq, bus.rd_valid, send_ch, start_ram_addr},
        32'd0);
    chk("t6_rst_timer", send_ch_timer | bus.read_data, 32'd0);
    rst = 0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
